// File: rtl/cpu_defs.sv
// Shared pipeline definitions: datapath widths and the ALU opcode encoding
// used by decode, execute and the ALU.
package cpu_defs;

    localparam int DATA_WIDTH = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALUOP_W    = 4;

    localparam logic [ALUOP_W-1:0] ALU_AND  = 4'd0;
    localparam logic [ALUOP_W-1:0] ALU_OR   = 4'd1;
    localparam logic [ALUOP_W-1:0] ALU_ADD  = 4'd2;
    localparam logic [ALUOP_W-1:0] ALU_LUI  = 4'd3;
    localparam logic [ALUOP_W-1:0] ALU_SLTU = 4'd4;
    localparam logic [ALUOP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALUOP_W-1:0] ALU_SUB  = 4'd6;
    localparam logic [ALUOP_W-1:0] ALU_SLT  = 4'd7;

    // True for the opcodes whose signed overflow may raise a trap.
    function automatic logic alu_op_can_ovf(input logic [ALUOP_W-1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/exe_stage_alu.sv
// Combinational ALU of the execute stage. Overflow is the signed overflow of
// ADD/SUB and is meaningless for other opcodes.
module ALU
    import cpu_defs::*;
#(
    parameter int DATA_WIDTH_P = DATA_WIDTH
) (
    input  logic [DATA_WIDTH_P-1:0] A,
    input  logic [DATA_WIDTH_P-1:0] B,
    input  logic [ALUOP_W-1:0]      ALUop,
    output logic [DATA_WIDTH_P-1:0] Result,
    output logic                    Overflow
);

    logic [DATA_WIDTH_P-1:0] sum;
    logic [DATA_WIDTH_P-1:0] diff;
    logic                    add_ovf;
    logic                    sub_ovf;

    assign sum  = A + B;
    assign diff = A - B;

    // Signed overflow: result sign disagrees with what the operand signs imply.
    assign add_ovf = (A[DATA_WIDTH_P-1] == B[DATA_WIDTH_P-1]) &&
                     (sum[DATA_WIDTH_P-1] != A[DATA_WIDTH_P-1]);
    assign sub_ovf = (A[DATA_WIDTH_P-1] != B[DATA_WIDTH_P-1]) &&
                     (diff[DATA_WIDTH_P-1] != A[DATA_WIDTH_P-1]);

    always_comb begin
        Result   = '0;
        Overflow = 1'b0;
        case (ALUop)
            ALU_AND:  Result = A & B;
            ALU_OR:   Result = A | B;
            ALU_ADD: begin
                Result   = sum;
                Overflow = add_ovf;
            end
            ALU_LUI:  Result = {B[15:0], {(DATA_WIDTH_P-16){1'b0}}};
            ALU_SLTU: Result = {{(DATA_WIDTH_P-1){1'b0}}, (A < B)};
            ALU_SLL:  Result = B << A[4:0];
            ALU_SUB: begin
                Result   = diff;
                Overflow = sub_ovf;
            end
            ALU_SLT:  Result = {{(DATA_WIDTH_P-1){1'b0}}, ($signed(A) < $signed(B))};
            default:  Result = '0;
        endcase
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: one pipeline register set, the ALU, exception gating of the
// write/memory enables, and the bypass/load-hazard view exported to decode.
module exe_stage
    import cpu_defs::*;
#(
    parameter int DATA_WIDTH_P = DATA_WIDTH,
    parameter int REG_ADDR_W_P = REG_ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,

    input  logic                    de_to_es_valid,
    output logic                    es_allowin,
    input  logic [ALUOP_W-1:0]      de_alu_op,
    input  logic [DATA_WIDTH_P-1:0] de_src1,
    input  logic [DATA_WIDTH_P-1:0] de_src2,
    input  logic [REG_ADDR_W_P-1:0] de_dest,
    input  logic                    de_rf_we,
    input  logic                    de_mem_re,
    input  logic                    de_mem_we,
    input  logic [DATA_WIDTH_P-1:0] de_store_data,
    input  logic                    de_ov_trap,
    input  logic [DATA_WIDTH_P-1:0] de_pc,

    input  logic                    ms_allowin,
    output logic                    es_to_ms_valid,
    output logic [DATA_WIDTH_P-1:0] es_alu_result,
    output logic [REG_ADDR_W_P-1:0] es_dest,
    output logic                    es_rf_we,
    output logic                    es_mem_re,
    output logic                    es_mem_we,
    output logic [DATA_WIDTH_P-1:0] es_store_data,
    output logic [DATA_WIDTH_P-1:0] es_pc,
    output logic                    es_ov_exc,

    output logic                    es_fwd_we,
    output logic [REG_ADDR_W_P-1:0] es_fwd_dest,
    output logic [DATA_WIDTH_P-1:0] es_fwd_data,
    output logic                    es_load_hazard
);

    logic                    es_valid;
    logic [ALUOP_W-1:0]      r_alu_op;
    logic [DATA_WIDTH_P-1:0] r_src1;
    logic [DATA_WIDTH_P-1:0] r_src2;
    logic [REG_ADDR_W_P-1:0] r_dest;
    logic                    r_rf_we;
    logic                    r_mem_re;
    logic                    r_mem_we;
    logic [DATA_WIDTH_P-1:0] r_store_data;
    logic                    r_ov_trap;
    logic [DATA_WIDTH_P-1:0] r_pc;

    logic                    es_ready_go;
    logic [DATA_WIDTH_P-1:0] alu_result;
    logic                    alu_ovf;
    logic                    ov;
    logic                    dest_nz;

    // Handshake: a transfer happens on a rising edge where the producer's
    // valid and the consumer's allowin are both 1; the payload must be stable
    // while valid is high and allowin is low, and flush overrides both sides.
    assign es_ready_go    = 1'b1;
    assign es_allowin     = ~es_valid | (es_ready_go & ms_allowin) | flush;
    assign es_to_ms_valid = es_valid & es_ready_go & ~flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            es_valid     <= 1'b0;
            r_alu_op     <= '0;
            r_src1       <= '0;
            r_src2       <= '0;
            r_dest       <= '0;
            r_rf_we      <= 1'b0;
            r_mem_re     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_store_data <= '0;
            r_ov_trap    <= 1'b0;
            r_pc         <= '0;
        end else if (flush) begin
            es_valid <= 1'b0;
        end else if (es_allowin) begin
            es_valid <= de_to_es_valid;
            if (de_to_es_valid) begin
                r_alu_op     <= de_alu_op;
                r_src1       <= de_src1;
                r_src2       <= de_src2;
                r_dest       <= de_dest;
                r_rf_we      <= de_rf_we;
                r_mem_re     <= de_mem_re;
                r_mem_we     <= de_mem_we;
                r_store_data <= de_store_data;
                r_ov_trap    <= de_ov_trap;
                r_pc         <= de_pc;
            end
        end
    end

    ALU #(
        .DATA_WIDTH_P(DATA_WIDTH_P)
    ) u_alu (
        .A        (r_src1),
        .B        (r_src2),
        .ALUop    (r_alu_op),
        .Result   (alu_result),
        .Overflow (alu_ovf)
    );

    // A trapping overflow suppresses every architectural side effect but
    // still travels down the pipe so the exception can be taken later.
    assign ov      = es_valid & r_ov_trap & alu_op_can_ovf(r_alu_op) & alu_ovf;
    assign dest_nz = (r_dest != '0);

    assign es_alu_result = alu_result;
    assign es_dest       = r_dest;
    assign es_rf_we      = es_valid & r_rf_we  & ~ov;
    assign es_mem_re     = es_valid & r_mem_re & ~ov;
    assign es_mem_we     = es_valid & r_mem_we & ~ov;
    assign es_store_data = r_store_data;
    assign es_pc         = r_pc;
    assign es_ov_exc     = ov;

    // Load data is not known until memory, so loads are reported as a hazard
    // instead of being bypassed.
    assign es_fwd_we      = es_rf_we & ~r_mem_re & dest_nz;
    assign es_fwd_dest    = r_dest;
    assign es_fwd_data    = alu_result;
    assign es_load_hazard = es_valid & r_mem_re & dest_nz;

endmodule

// File: doc/exe_stage.md
# exe_stage

Execute stage of the 5-stage MIPS pipeline. Latches one decoded instruction from the decode stage through a valid/allowin handshake and drives the combinational `ALU` from the latched operands. Presents the result, memory controls and store data to the memory stage. Exports a forwarding/hazard view of the resident instruction back to decode.

## Interface
Parameters:
- DATA_WIDTH, 32, operand/result width
- REG_ADDR_W, 5, register-file index width

Ports (clock and reset first):
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  kill resident instruction and refuse input this cycle
- de_to_es_valid  in  1  decode offers an instruction
- es_allowin  out  1  stage can accept this cycle
- de_alu_op  in  4  ALU opcode: AND 0, OR 1, ADD 2, LUI 3, SLTU 4, SLL 5, SUB 6, SLT 7
- de_src1 / de_src2  in  32  ALU A / B (already forwarded by decode)
- de_dest  in  5  destination register
- de_rf_we  in  1  writes register file
- de_mem_re / de_mem_we  in  1  load / store
- de_store_data  in  32  store data
- de_ov_trap  in  1  trap on signed overflow (add/sub, not addu/subu)
- de_pc  in  32  instruction PC
- ms_allowin  in  1  memory stage can accept
- es_to_ms_valid  out  1  instruction offered to memory stage
- es_alu_result  out  32  ALU Result (load/store address for memory ops)
- es_dest  out  5; es_rf_we, es_mem_re, es_mem_we  out  1 each; es_store_data  out  32; es_pc  out  32
- es_ov_exc  out  1  overflow exception flag
- es_fwd_we  out  1; es_fwd_dest  out  5; es_fwd_data  out  32  bypass to decode
- es_load_hazard  out  1  resident load targets a nonzero register; decode stalls on match

## Operation
- One stage register set: es_valid plus the latched de_* payload.
- es_ready_go = 1 (single-cycle ALU). es_allowin = ~es_valid | ms_allowin | flush.
- Clock edge, in priority order:
  - rst: es_valid←0, all payload←0.
  - flush: es_valid←0; the offered input is discarded.
  - es_allowin: es_valid←de_to_es_valid; payload loads only when de_to_es_valid=1.
  - Otherwise (stall): hold everything.
- ALU A=src1, B=src2, op=alu_op. SLL shifts B by A[4:0]. LUI returns {B[15:0],16'h0}. SLT is signed; SLTU is unsigned.
- ov = es_valid & ov_trap & (op==ADD | op==SUB) & ALU.Overflow.
- es_ov_exc = ov. When ov=1, es_rf_we, es_mem_re and es_mem_we are forced 0; es_to_ms_valid stays 1 so the exception travels down.
- es_to_ms_valid = es_valid & ~flush. Payload outputs equal the latched values, gated by es_valid where listed.
- es_fwd_we = es_valid & es_rf_we(effective) & ~es_mem_re & (dest≠0). es_fwd_data = es_alu_result.
- es_load_hazard = es_valid & mem_re & (dest≠0).

## Timing
- Reset values: es_allowin=1 and every other output 0. Holds from the first edge with rst=1 until the first accepted instruction.
- Latency: an instruction accepted at edge N shows its result on es_alu_result during cycle N..N+1. It is handed to memory at the first edge with ms_allowin=1.
- Throughput: 1 instr/cycle while ms_allowin=1.
- Backpressure: es_valid=1 and ms_allowin=0 gives es_allowin=0, and payload and outputs stay stable.
- Simultaneous accept and hand-off: the new payload replaces the old on the same edge; no bubble.
- Flush together with de_to_es_valid: the input is dropped and the next cycle es_valid=0.
- Reset mid-stall: the stage empties and in-flight payload is lost.
- Outputs are combinational from stage registers; no input-to-output combinational path except flush→es_allowin/es_to_ms_valid and ms_allowin→es_allowin.

## Structure
- Shared package/header `cpu_defs`: DATA_WIDTH, REG_ADDR_W, and the ALU opcode constants listed above. The `ALU` and decode stage use the same constants.
- One sub-module instance: `ALU` (4-bit ALUop). The stage register, effective-enable gating and forwarding logic live in exe_stage.

## Test plan
- Reset: hold rst 2 cycles → es_allowin=1, es_to_ms_valid=0, es_fwd_we=0, es_alu_result=0.
- Back-to-back ADD 5+7 (dest 3) then SUB 5−7 (dest 4), ms_allowin=1 → results 12 then 0xFFFFFFFE on consecutive cycles; es_fwd_dest 3 then 4.
- ADD 0x7FFFFFFF+1 with ov_trap=1 → es_ov_exc=1, es_rf_we=0, es_to_ms_valid=1. Same with ov_trap=0 → result 0x80000000, es_rf_we=1.
- Stall: accept SLT 0xFFFFFFFF,1, drop ms_allowin for 3 cycles while de_to_es_valid=1 → es_allowin=0, result holds 1, the next instruction enters only after ms_allowin rises.
- Load LW dest 8 → es_load_hazard=1, es_fwd_we=0. Load with dest 0 → es_load_hazard=0.
- Flush while resident and with a new offer → next cycle es_valid=0 and no output; SLL A=4,B=1 offered afterward → 0x10.
